// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract unit: STAGES registered slices with GROUP-bit lookahead blocks per slice.
// Define ADDER_SAT_EN to add the sat port and signed-saturation clamping in the final stage.

module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef ADDER_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int SW   = WIDTH / STAGES;
    localparam int NG   = SW / GROUP;
    localparam int LAST = STAGES - 1;

    typedef struct packed {
        logic [SW-1:0] s;
        logic          co;
        logic          c_top;
    } slice_res_t;

    // Full lookahead inside each GROUP-bit block; the block carry ripples into the next block.
    function automatic slice_res_t cla_slice(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic ci);
        logic [SW-1:0] p;
        logic [SW-1:0] g;
        logic [SW:0]   c;
        logic          gen_any;
        logic          prop_all;
        logic          term;
        slice_res_t    r;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = ci;
        for (int grp = 0; grp < NG; grp++) begin
            for (int i = grp * GROUP; i < (grp + 1) * GROUP; i++) begin
                gen_any  = 1'b0;
                prop_all = c[grp * GROUP];
                for (int j = grp * GROUP; j <= i; j++) begin
                    term = g[j];
                    for (int m = j + 1; m <= i; m++) begin
                        term = term & p[m];
                    end
                    gen_any  = gen_any | term;
                    prop_all = prop_all & p[j];
                end
                c[i + 1] = gen_any | prop_all;
            end
        end
        r.s     = p ^ c[SW-1:0];
        r.co    = c[SW];
        r.c_top = c[SW-1];
        return r;
    endfunction

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] carry_d;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic              sat_q [STAGES];
    logic              sat_d [STAGES];
    logic              ovf_q;
    logic              ovf_d;
    logic              zero_q;
    logic              zero_d;
    logic              neg_q;
    logic              neg_d;

    logic [STAGES-1:0] take_s;
    logic [STAGES-1:0] feed_v_s;
    logic [STAGES-1:0] feed_c_s;
    logic [WIDTH-1:0]  feed_a_s [STAGES];
    logic [WIDTH-1:0]  feed_b_s [STAGES];
    logic [WIDTH-1:0]  feed_sum_s [STAGES];
    logic              feed_sat_s [STAGES];
    logic              sat_in_s;
    slice_res_t        res_s;
    logic [WIDTH-1:0]  nsum_s;
    logic              wrap_ovf_s;

`ifdef ADDER_SAT_EN
    assign sat_in_s = sat;
`else
    assign sat_in_s = 1'b0;
`endif

    // Stage k loads when it is empty or every stage downstream of it is moving.
    always_comb begin
        take_s       = '0;
        take_s[LAST] = ~valid_q[LAST] | out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            take_s[k] = ~valid_q[k] | take_s[k + 1];
        end
    end

    // Stage inputs: the raw (b-inverted on subtract) operands for slice 0, the previous stage otherwise.
    always_comb begin
        feed_v_s   = '0;
        feed_c_s   = '0;
        feed_a_s   = '{default: '0};
        feed_b_s   = '{default: '0};
        feed_sum_s = '{default: '0};
        feed_sat_s = '{default: 1'b0};
        feed_v_s[0]   = in_valid;
        feed_a_s[0]   = a;
        feed_b_s[0]   = sub ? ~b : b;
        feed_c_s[0]   = sub ? ~cin : cin;
        feed_sat_s[0] = sat_in_s;
        for (int k = 1; k < STAGES; k++) begin
            feed_v_s[k]   = valid_q[k - 1];
            feed_a_s[k]   = opa_q[k - 1];
            feed_b_s[k]   = opb_q[k - 1];
            feed_c_s[k]   = carry_q[k - 1];
            feed_sat_s[k] = sat_q[k - 1];
            feed_sum_s[k] = sum_q[k - 1];
        end
    end

    // Per-stage slice add; the final stage also derives the flags and applies optional clamping.
    always_comb begin
        valid_d    = valid_q;
        carry_d    = carry_q;
        sum_d      = sum_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        sat_d      = sat_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        res_s      = '0;
        nsum_s     = '0;
        wrap_ovf_s = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            res_s  = cla_slice(feed_a_s[k][k*SW +: SW], feed_b_s[k][k*SW +: SW], feed_c_s[k]);
            nsum_s = feed_sum_s[k];
            nsum_s[k*SW +: SW] = res_s.s;
            if (take_s[k]) begin
                valid_d[k] = feed_v_s[k];
                if (feed_v_s[k]) begin
                    opa_d[k]   = feed_a_s[k];
                    opb_d[k]   = feed_b_s[k];
                    carry_d[k] = res_s.co;
                    sat_d[k]   = feed_sat_s[k];
                    if (k == LAST) begin
                        wrap_ovf_s = res_s.c_top ^ res_s.co;
                        if (feed_sat_s[k] && wrap_ovf_s) begin
                            // A wrapped negative sum means positive overflow, and vice versa.
                            nsum_s = nsum_s[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
                        end else begin
                            nsum_s = nsum_s;
                        end
                        ovf_d  = wrap_ovf_s;
                        zero_d = (nsum_s == {WIDTH{1'b0}});
                        neg_d  = nsum_s[WIDTH-1];
                    end else begin
                        wrap_ovf_s = 1'b0;
                    end
                    sum_d[k] = nsum_s;
                end else begin
                    sum_d[k] = sum_q[k];
                end
            end else begin
                valid_d[k] = valid_q[k];
            end
        end
    end

    // Pipeline state; reset drops every in-flight beat and clears the visible result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            carry_q <= '0;
            sum_q   <= '{default: '0};
            opa_q   <= '{default: '0};
            opb_q   <= '{default: '0};
            sat_q   <= '{default: 1'b0};
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = take_s[0];
    assign out_valid = valid_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = carry_q[LAST];
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and reference-model bench for pipelined_cla_adder (32/4/2 instance plus a 16/4/4 instance).
// Saturation vectors are included when ADDER_SAT_EN is defined.

module tb_pipelined_cla_adder;

    localparam int W   = 32;
    localparam int S   = 2;
    localparam int HW  = 16;
    localparam int HS  = 4;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a         = '0;
    logic [W-1:0]  b         = '0;
    logic          cin       = 1'b0;
    logic          sub       = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic          cout, ovf, zero, neg;

    logic          h_in_valid  = 1'b0;
    logic          h_in_ready;
    logic [HW-1:0] h_a         = '0;
    logic [HW-1:0] h_b         = '0;
    logic          h_cin       = 1'b0;
    logic          h_sub       = 1'b0;
    logic          h_out_valid;
    logic          h_out_ready = 1'b1;
    logic [HW-1:0] h_sum;
    logic          h_cout, h_ovf, h_zero, h_neg;
`ifdef ADDER_SAT_EN
    logic          sat   = 1'b0;
    logic          h_sat = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(4), .STAGES(S)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef ADDER_SAT_EN
        .sat(sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    pipelined_cla_adder #(.WIDTH(HW), .GROUP(4), .STAGES(HS)) dut16 (
        .clk(clk), .reset_n(reset_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .cin(h_cin), .sub(h_sub),
`ifdef ADDER_SAT_EN
        .sat(h_sat),
`endif
        .out_valid(h_out_valid), .out_ready(h_out_ready), .sum(h_sum),
        .cout(h_cout), .ovf(h_ovf), .zero(h_zero), .neg(h_neg)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({out_valid, cout, ovf, zero, neg} !== 5'b00000) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {out_valid, cout, ovf, zero, neg}); end
        n_checks++; if (sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h expected 00000000", sum); end
        n_checks++; if (h_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid16: got %b expected 0", h_out_valid); end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (h_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready16: got %b expected 1", h_in_ready); end
    endtask

    task automatic test_arith();
        logic [31:0] ta [10] = '{32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000005, 32'h00000000,
                                 32'h12345678, 32'h0000000A, 32'h0000FFFF, 32'h80000000, 32'h00000000};
        logic [31:0] tv [10] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000005, 32'h00000001,
                                 32'h11111111, 32'h00000003, 32'h00000001, 32'h80000000, 32'h00000000};
        logic [1:0]  tcs [10] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b11};
        logic [31:0] tsum [10] = '{32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'hFFFFFFFF,
                                   32'h2345678A, 32'h00000006, 32'h00010000, 32'h00000000, 32'hFFFFFFFF};
        logic [3:0]  tflg [10] = '{4'b1010, 4'b1100, 4'b0101, 4'b1010, 4'b0001,
                                   4'b0000, 4'b1000, 4'b0000, 4'b1110, 4'b0001};
        for (int i = 0; i < 10; i++) begin
            int w;
            @(negedge clk);
            a = ta[i]; b = tv[i]; {cin, sub} = tcs[i]; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arith[%0d] in_ready: got %b expected 1", i, in_ready); end
            @(negedge clk);
            in_valid = 1'b0; a = ~ta[i]; b = 32'hA5A5A5A5; cin = ~cin; sub = ~sub;
            w = 1;
            while (out_valid !== 1'b1 && w < 8) begin
                @(negedge clk);
                w++;
            end
            n_checks++; if (w !== S) begin n_fail++; $display("FAIL arith[%0d] latency: got %0d expected %0d", i, w, S); end
            n_checks++; if (sum !== tsum[i]) begin n_fail++; $display("FAIL arith[%0d] sum: got %h expected %h", i, sum, tsum[i]); end
            n_checks++; if ({cout, ovf, zero, neg} !== tflg[i]) begin n_fail++; $display("FAIL arith[%0d] flags(c,v,z,n): got %b expected %b", i, {cout, ovf, zero, neg}, tflg[i]); end
        end
        @(negedge clk);
    endtask

`ifdef ADDER_SAT_EN
    task automatic test_saturation();
        logic [31:0] ta [3]   = '{32'h80000000, 32'h7FFFFFFF, 32'h00000005};
        logic [31:0] tv [3]   = '{32'h00000001, 32'h00000001, 32'h00000005};
        logic        ts [3]   = '{1'b1, 1'b0, 1'b1};
        logic [31:0] tsum [3] = '{32'h80000000, 32'h7FFFFFFF, 32'h00000000};
        logic [3:0]  tflg [3] = '{4'b1101, 4'b0100, 4'b1010};
        for (int i = 0; i < 3; i++) begin
            int w;
            @(negedge clk);
            a = ta[i]; b = tv[i]; cin = 1'b0; sub = ts[i]; sat = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0; sat = 1'b0;
            w = 1;
            while (out_valid !== 1'b1 && w < 8) begin
                @(negedge clk);
                w++;
            end
            n_checks++; if (sum !== tsum[i]) begin n_fail++; $display("FAIL sat[%0d] sum: got %h expected %h", i, sum, tsum[i]); end
            n_checks++; if ({cout, ovf, zero, neg} !== tflg[i]) begin n_fail++; $display("FAIL sat[%0d] flags(c,v,z,n): got %b expected %b", i, {cout, ovf, zero, neg}, tflg[i]); end
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_sweep16();
        logic [15:0] va [3]  = '{16'h7FFF, 16'hFFFF, 16'h0000};
        logic [15:0] vb [3]  = '{16'h0001, 16'h0000, 16'h0001};
        logic [1:0]  vcs [3] = '{2'b10, 2'b10, 2'b01};
        logic [15:0] vs [3]  = '{16'h8001, 16'h0000, 16'hFFFF};
        logic [3:0]  vf [3]  = '{4'b0101, 4'b1010, 4'b0001};
        for (int i = 0; i < 3; i++) begin
            int w;
            @(negedge clk);
            h_a = va[i]; h_b = vb[i]; {h_cin, h_sub} = vcs[i]; h_in_valid = 1'b1; h_out_ready = 1'b1;
            @(negedge clk);
            h_in_valid = 1'b0; h_a = 16'h5A5A; h_b = 16'hFFFF;
            w = 1;
            while (h_out_valid !== 1'b1 && w < 10) begin
                @(negedge clk);
                w++;
            end
            n_checks++; if (w !== HS) begin n_fail++; $display("FAIL sweep16[%0d] latency: got %0d expected %0d", i, w, HS); end
            n_checks++; if (h_sum !== vs[i]) begin n_fail++; $display("FAIL sweep16[%0d] sum: got %h expected %h", i, h_sum, vs[i]); end
            n_checks++; if ({h_cout, h_ovf, h_zero, h_neg} !== vf[i]) begin n_fail++; $display("FAIL sweep16[%0d] flags(c,v,z,n): got %b expected %b", i, {h_cout, h_ovf, h_zero, h_neg}, vf[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q [4] = '{32'd2, 32'd4, 32'd6, 32'd8};
        int sent = 0;
        int got  = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 4) ? 1'b1 : 1'b0;
            in_valid  = (sent < 4) ? 1'b1 : 1'b0;
            a = 32'(sent + 1); b = 32'(sent + 1); cin = 1'b0; sub = 1'b0;
            #1;
            if (cyc == 2 || cyc == 3) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp cyc%0d in_ready: got %b expected 0", cyc, in_ready); end
                n_checks++; if (out_valid !== 1'b1 || sum !== 32'd2) begin n_fail++; $display("FAIL bp cyc%0d held: got v=%b sum=%h expected v=1 sum=00000002", cyc, out_valid, sum); end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_checks++;
                if (got >= 4 || sum !== exp_q[got]) begin n_fail++; $display("FAIL bp order[%0d]: got %h expected %h", got, sum, (got < 4) ? exp_q[got] : 32'hx); end
                got++;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (got !== 4) begin n_fail++; $display("FAIL bp count: got %0d expected 4", got); end
    endtask

    task automatic test_throughput();
        logic [35:0] exp_q [$];
        logic [35:0] exp_v;
        logic [31:0] ra, rb, beff;
        logic        rc, rs, ceff;
        logic [32:0] full;
        logic        need = 1'b1;
        int sent = 0, got = 0, first_in = -1, last_out = -1;
        ra = '0; rb = '0; rc = 1'b0; rs = 1'b0;
        for (int cyc = 0; cyc < 300 && got < 100; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (sent < 100) begin
                if (need) begin
                    ra = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom();
                    rb = ($urandom_range(0, 3) == 0) ? 32'h00000001 : $urandom();
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'($urandom_range(0, 1));
                    need = 1'b0;
                end
                in_valid = 1'b1; a = ra; b = rb; cin = rc; sub = rs;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL tput extra result: got %h expected none", sum);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({cout, ovf, zero, neg, sum} !== exp_v) begin n_fail++; $display("FAIL tput beat %0d: got %h expected %h", got, {cout, ovf, zero, neg, sum}, exp_v); end
                end
                got++;
                last_out = cyc;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                beff = rs ? ~rb : rb;
                ceff = rs ? ~rc : rc;
                full = {1'b0, ra} + {1'b0, beff} + {32'd0, ceff};
                exp_v = {full[32], (ra[31] == beff[31]) && (full[31] != ra[31]), full[31:0] == 32'd0, full[31], full[31:0]};
                exp_q.push_back(exp_v);
                if (first_in < 0) first_in = cyc;
                sent++;
                need = 1'b1;
            end
        end
        in_valid = 1'b0;
        n_checks++; if (got !== 100) begin n_fail++; $display("FAIL tput count: got %0d expected 100", got); end
        n_checks++; if (last_out - first_in !== 100 + S - 1) begin n_fail++; $display("FAIL tput cycles: got %0d expected %0d", last_out - first_in, 100 + S - 1); end
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'(i); b = 32'd1; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
            h_in_valid = 1'b1; h_a = 16'(i); h_b = 16'd1; h_cin = 1'b0; h_sub = 1'b0; h_out_ready = 1'b1;
        end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst pre out_valid: got %b expected 1", out_valid); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || h_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst out_valid: got %b/%b expected 0/0", out_valid, h_out_valid); end
        n_checks++; if (sum !== 32'h0) begin n_fail++; $display("FAIL midrst sum: got %h expected 00000000", sum); end
        @(negedge clk);
        #2 reset_n = 1'b1;
        in_valid = 1'b0; h_in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1 || h_in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst in_ready: got %b/%b expected 1/1", in_ready, h_in_ready); end
        for (int c = 0; c < 6; c++) begin
            if (out_valid !== 1'b0 || h_out_valid !== 1'b0) stale++;
            @(negedge clk);
        end
        n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL midrst stale: got %0d stale cycles expected 0", stale); end
    endtask

    initial begin
        test_reset();
        test_arith();
`ifdef ADDER_SAT_EN
        test_saturation();
`endif
        test_sweep16();
        test_backpressure();
        test_throughput();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
